// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receiver: default frame geometry, receiver
// states and the parity-check helper.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 32;
  localparam int unsigned DATA_BITS_DEF    = 8;
  localparam int unsigned FRAME_W          = DATA_BITS_DEF + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Pass the XOR-reduction of the data bits; true when data plus parity bit
  // does not give the expected sense.
  function automatic logic parity_mismatch(input logic data_xor, input logic par_bit,
                                           input logic odd);
    return (data_xor ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous Rx line; resets to the idle (high) level
// so a reset never manufactures a start edge.
module rx_sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, parity bit, stop bit.
// Emits {parity_bit, data} with a one-cycle strobe and held error flags.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx,
  output logic [DATA_BITS:0] o_frame,
  output logic               o_frame_valid,
  output logic               o_parity_err,
  output logic               o_stop_err,
  output logic               o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be even and at least 4");
  end

  rx_state_e              r_state;
  rx_state_e              w_state_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [BIT_W-1:0]       r_bit_idx;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_par;
  logic                   r_rx_prev;
  logic [DATA_BITS:0]     r_frame;
  logic                   r_frame_valid;
  logic                   r_parity_err;
  logic                   r_stop_err;
  logic                   w_rx_s;
  logic                   w_mid;
  logic                   w_data_smp;
  logic                   w_par_smp;
  logic                   w_stop_smp;

  rx_sync_2ff u_rx_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (w_rx_s)
  );

  // The START half-bit offset puts every later CNT_LAST compare at mid-bit.
  assign w_mid = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_data_smp = 1'b0;
    w_par_smp  = 1'b0;
    w_stop_smp = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_rx_prev && !w_rx_s) w_state_d = START;
      end
      START: begin
        if (r_cnt == CNT_HALF) w_state_d = w_rx_s ? IDLE : DATA;
      end
      DATA: begin
        w_data_smp = w_mid;
        if (w_mid && r_bit_idx == BIT_LAST) w_state_d = PARITY;
      end
      PARITY: begin
        w_par_smp = w_mid;
        if (w_mid) w_state_d = STOP;
      end
      STOP: begin
        w_stop_smp = w_mid;
        if (w_mid) w_state_d = w_rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        if (w_rx_s) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_data        <= '0;
      r_par         <= 1'b0;
      r_rx_prev     <= 1'b1;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_parity_err  <= 1'b0;
      r_stop_err    <= 1'b0;
    end else begin
      r_rx_prev     <= w_rx_s;
      r_frame_valid <= w_stop_smp;
      if (w_state_d != r_state || r_state == IDLE || r_state == BREAK || w_mid) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state != DATA) begin
        r_bit_idx <= '0;
      end else if (w_data_smp) begin
        r_bit_idx <= r_bit_idx + BIT_W'(1);
        r_data    <= {w_rx_s, r_data[DATA_BITS-1:1]};
      end
      if (w_par_smp) r_par <= w_rx_s;
      if (w_stop_smp) begin
        r_frame      <= {r_par, r_data};
        r_parity_err <= parity_mismatch(^r_data, r_par, PARITY_ODD);
        r_stop_err   <= ~w_rx_s;
      end
    end
  end

  assign o_frame       = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_parity_err  = r_parity_err;
  assign o_stop_err    = r_stop_err;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: directed frames plus randomized traffic, with
// expected frames queued at send time and checked by an independent strobe monitor.
module tb_uart_rx_frame;

  localparam int CPB = 32;

  typedef struct packed {
    logic [8:0] frame;
    logic       perr;
    logic       serr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [8:0] o_frame;
  logic       o_frame_valid;
  logic       o_parity_err;
  logic       o_stop_err;
  logic       o_busy;

  exp_t       q[$];
  int         checks  = 0;
  int         errors  = 0;
  int         strobes = 0;
  int         sent    = 0;
  logic [8:0] h_frame = '0;
  logic       h_perr  = 1'b0;
  logic       h_serr  = 1'b0;
  logic       rst_q   = 1'b1;

  always #5 clk = ~clk;

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .PARITY_ODD   (1'b0)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx          (rx),
    .o_frame       (o_frame),
    .o_frame_valid (o_frame_valid),
    .o_parity_err  (o_parity_err),
    .o_stop_err    (o_stop_err),
    .o_busy        (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame is {parity, data}; even parity expected; stop must be high.
  function automatic exp_t model(input logic [7:0] d, input logic p, input logic stop_ok);
    exp_t e;
    e.frame = {p, d};
    e.perr  = (($countones(d) + int'(p)) % 2) != 0;
    e.serr  = !stop_ok;
    return e;
  endfunction

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_q) begin
      q.delete();
      h_frame = '0;
      h_perr  = 1'b0;
      h_serr  = 1'b0;
    end
    if (o_frame_valid) begin
      strobes++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got frame %0h expected no strobe at %0t", o_frame,
                 $time);
      end else begin
        e = q.pop_front();
        chk("frame", 32'(o_frame), 32'(e.frame));
        chk("parity_err", 32'(o_parity_err), 32'(e.perr));
        chk("stop_err", 32'(o_stop_err), 32'(e.serr));
        h_frame = e.frame;
        h_perr  = e.perr;
        h_serr  = e.serr;
      end
    end else begin
      chk("hold", 32'({o_frame, o_parity_err, o_stop_err}), 32'({h_frame, h_perr, h_serr}));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_ok,
                            input int stop_clks);
    q.push_back(model(d, p, stop_ok));
    sent++;
    drive(1'b0, 8);
    chk("busy_start", 32'(o_busy), 32'd1);
    drive(1'b0, CPB - 8);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(p, CPB);
    if (stop_ok) begin
      drive(1'b1, CPB / 2 + 4);
      chk("busy_mid_stop", 32'(o_busy), 32'd0);
      tick(stop_clks - (CPB / 2 + 4));
    end else begin
      drive(1'b0, stop_clks);
      chk("busy_in_break", 32'(o_busy), 32'd1);
      drive(1'b1, CPB);
      chk("busy_after_break", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] d;
    logic [7:0] part;
    logic       p;
    logic       good;
    int         stop_clks;
    int         strobes_before;

    rst = 1'b1;
    rx  = 1'b1;
    tick(4);
    chk("reset_frame", 32'(o_frame), 32'd0);
    chk("reset_valid", 32'(o_frame_valid), 32'd0);
    chk("reset_perr", 32'(o_parity_err), 32'd0);
    chk("reset_serr", 32'(o_stop_err), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    tick(CPB);

    send_frame(8'h21, 1'b0, 1'b1, CPB);
    tick(CPB);

    // Next start edge 30 clocks after the stop bit begins.
    send_frame(8'h21, 1'b0, 1'b1, 30);
    send_frame(8'h2F, 1'b1, 1'b1, CPB);
    tick(CPB);

    send_frame(8'h21, 1'b1, 1'b1, CPB);
    send_frame(8'h2F, 1'b1, 1'b1, CPB);
    tick(CPB);

    strobes_before = strobes;
    drive(1'b0, 8);
    chk("glitch_busy_high", 32'(o_busy), 32'd1);
    drive(1'b1, 2 * CPB);
    chk("glitch_busy_low", 32'(o_busy), 32'd0);
    chk("glitch_no_strobe", 32'(strobes), 32'(strobes_before));
    send_frame(8'hA5, 1'b0, 1'b1, CPB);
    tick(CPB);

    send_frame(8'h3C, 1'b0, 1'b0, 3 * CPB);
    send_frame(8'h96, 1'b0, 1'b1, CPB);
    tick(CPB);

    // Abort in the middle of data bit 4.
    part = 8'hC3;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(part[i], CPB);
    drive(part[4], CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_frame", 32'(o_frame), 32'd0);
    chk("abort_valid", 32'(o_frame_valid), 32'd0);
    chk("abort_perr", 32'(o_parity_err), 32'd0);
    chk("abort_serr", 32'(o_stop_err), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    tick(CPB);
    send_frame(8'h5A, 1'b0, 1'b1, CPB);
    tick(CPB);

    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      p    = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      good = ($urandom_range(0, 7) != 0);
      if (good) stop_clks = ($urandom_range(0, 1) == 1) ? 30 : CPB;
      else      stop_clks = CPB * int'($urandom_range(1, 3));
      send_frame(d, p, good, stop_clks);
      tick(int'($urandom_range(0, CPB)));
    end

    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("strobe_count", 32'(strobes), 32'(sent));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Serial receiver that sits directly upstream of the channel processor. It turns the Rx line into 9-bit frames: 8 data bits plus the received parity bit.
- Frame format: 1 start bit, 8 data bits LSB first, 1 even-parity bit, 1 stop bit.
- Output: one-cycle frame_valid strobe with parity and stop error flags.
- The channel processor latches `frame` on `frame_valid`. Its debug_frame output mirrors this value.

Parameters:
- CLKS_PER_BIT, 32, clock cycles per serial bit (320 ns bit at 10 ns clk); must be even and >= 4.
- DATA_BITS, 8, data bits per frame.
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  serial line, idle high, asynchronous to clk
- frame  out  9  {parity_bit, data[7:0]}, data[0] = first bit received
- frame_valid  out  1  one-cycle strobe; frame/flags valid in the same cycle
- parity_err  out  1  parity mismatch on last frame; held until next frame_valid
- stop_err  out  1  stop bit sampled low on last frame; held until next frame_valid
- busy  out  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset:
  - frame=0, frame_valid=0, parity_err=0, stop_err=0, busy=0, state=IDLE.
  - Synchronizer flops reset to 1.
  - Bit and baud counters reset to 0.
- Input sync: rx passes through a 2-FF synchronizer (rx_s). X/undriven rx before the first edge must not leave IDLE; only a registered 1->0 transition of rx_s starts reception.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
- States:
  - IDLE: on falling edge of rx_s -> START, busy=1.
  - START: at count CLKS_PER_BIT/2-1, sample rx_s.
    - If 1 (glitch): -> IDLE, busy=0, no strobe.
    - Otherwise -> DATA.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), shift rx_s into data[bit_idx], LSB first. After DATA_BITS samples -> PARITY.
  - PARITY: sample at mid-bit into frame[8] -> STOP.
  - STOP: sample at mid-bit. Next cycle:
    - frame_valid=1, frame updated.
    - parity_err = (^data ^ parity_bit) != PARITY_ODD.
    - stop_err = ~stop_sample.
    - Stop sampled 1: -> IDLE.
    - Stop sampled 0: -> BREAK.
  - BREAK: wait until rx_s==1 for one cycle -> IDLE. No start detection while in BREAK.
- Latency: frame_valid rises 3 cycles after the mid-stop sample point on raw rx (2 sync + 1 register).
- Back-to-back frames: IDLE is re-entered at mid-stop. A new start edge 30 clks after stop-bit start must be captured.
- frame, parity_err and stop_err change only on frame_valid. They hold between strobes.
- Reset mid-frame: abort immediately, no strobe, outputs return to reset values.
- A frame is strobed even with errors. The consumer decides whether to discard it.

Decomposition:
- Shared package uart_pkg:
  - State enum/localparams: IDLE, START, DATA, PARITY, STOP, BREAK.
  - FRAME_W = DATA_BITS+1.
  - Default CLKS_PER_BIT.
- One sub-module: rx_sync_2ff, a 2-flop synchronizer with reset-to-1.

Test Plan:
- Data 0x21 (bits 1,0,0,0,0,1,0,0), parity 0, stop 1 at 32 clk/bit -> single frame_valid; frame=9'h021, parity_err=0, stop_err=0, busy falls at mid-stop.
- 0x21 frame followed 30 clks after its stop start by 0x2F with parity 1 -> two strobes: frame=9'h021, then 9'h12F, both error-free.
- 0x21 with parity bit 1 -> frame=9'h121, parity_err=1. A following clean 0x2F frame clears parity_err to 0.
- rx low for 8 clks, then high -> no frame_valid, busy pulses then returns 0, state IDLE; a subsequent good frame is received normally.
- Stop bit driven 0 for 3 bit times -> frame_valid with stop_err=1; no new start detected until rx returns high; the next frame decodes correctly.
- rst asserted for 1 cycle during DATA bit 4 -> no strobe, all outputs 0; a complete frame sent after rst deasserts decodes correctly.
